// File: rtl/spi_subnode_pkg.sv
// spi_subnode_pkg: FSM states and command-byte layout for the SPI register subnode.
package spi_subnode_pkg;
    typedef enum logic [2:0] {IDLE, CMD, WR, RD, DRAIN} state_t;
    localparam int CMD_W  = 8;
    localparam int RD_BIT = 7;
    localparam int ADDR_W = 7;
endpackage

// File: rtl/spi_regfile_subnode_if.sv
// spi_regfile_subnode_if: SPI pin bundle between a bus master and the register subnode.
interface spi_regfile_subnode_if;
    logic sck;
    logic csb;
    logic mosi;
    logic miso;
    logic miso_oe;
    modport master (output sck, csb, mosi, input miso, miso_oe);
    modport slave (input sck, csb, mosi, output miso, miso_oe);
endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-flop synchroniser with one-clk rise/fall pulses on the synchronised level.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);
    logic [2:0] r;
    always_ff @(posedge clk or posedge rst)
        if (rst) r <= {3{RST_VAL}};
        else r <= {r[1:0], d};
    assign rise = r[1] & ~r[2];
    assign fall = ~r[1] & r[2];
endmodule

// File: rtl/spi_regfile_subnode.sv
// spi_regfile_subnode: SPI mode-0 register file with burst writes, snapshot reads and a sticky frame error.
module spi_regfile_subnode
    import spi_subnode_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int NUM_WR = 3,
    parameter int NUM_RO = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    spi_regfile_subnode_if.slave     spi,
    output logic [NUM_WR*DATA_W-1:0] wr_regs,
    output logic [NUM_WR-1:0]        wr_strobe,
    input  logic [NUM_RO*DATA_W-1:0] ro_regs,
    output logic                     frame_err
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam int NUM_ALL = NUM_WR + NUM_RO;
    localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(CMD_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    state_t state, state_n;
    logic sck_rise, sck_fall, csb_rise, csb_fall;
    logic [1:0] mosi_q;
    logic mosi_s;
    logic [CNT_W-1:0] bit_cnt;
    logic [CMD_W-2:0] cmd;
    logic [CMD_W-1:0] cmd_full;
    logic [ADDR_W-1:0] addr, addr_inc, cmd_addr;
    logic [DATA_W-2:0] shadow;
    logic [DATA_W-1:0] tx, word_cmd, word_next;
    logic [NUM_ALL*DATA_W-1:0] words;
    logic miso_r, oe_r, is_last, cmd_ok, last_wr, last_all;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sck (.clk(clk), .rst(rst), .d(spi.sck), .rise(sck_rise), .fall(sck_fall));
    spi_sync_edge #(.RST_VAL(1'b1)) u_csb (.clk(clk), .rst(rst), .d(spi.csb), .rise(csb_rise), .fall(csb_fall));

    // mosi shares the sck synchroniser depth so a sampled bit lines up with its rise pulse
    always_ff @(posedge clk or posedge rst)
        if (rst) mosi_q <= '0;
        else mosi_q <= {mosi_q[0], spi.mosi};

    assign mosi_s   = mosi_q[1];
    assign cmd_full = {cmd, mosi_s};
    assign cmd_addr = cmd_full[ADDR_W-1:0];
    assign addr_inc = addr + 1'b1;
    assign is_last  = bit_cnt == (state == CMD ? CMD_LAST : DATA_LAST);
    assign cmd_ok   = cmd_full[RD_BIT] ? int'(cmd_addr) < NUM_ALL : int'(cmd_addr) < NUM_WR;
    assign last_wr  = int'(addr) == NUM_WR - 1;
    assign last_all = int'(addr) == NUM_ALL - 1;
    assign words    = {ro_regs, wr_regs};
    assign spi.miso    = miso_r;
    assign spi.miso_oe = oe_r;

    always_comb begin
        word_cmd = '0;
        word_next = '0;
        for (int i = 0; i < NUM_ALL; i++) begin
            if (cmd_addr == ADDR_W'(i)) word_cmd = words[i*DATA_W +: DATA_W];
            if (addr_inc == ADDR_W'(i)) word_next = words[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;

    always_comb begin
        state_n = state;
        if (csb_rise) state_n = IDLE;
        else if (state == IDLE) state_n = csb_fall ? CMD : IDLE;
        else if (sck_rise && is_last && state != DRAIN)
            state_n = state == CMD ? (!cmd_ok ? DRAIN : cmd_full[RD_BIT] ? RD : WR)
                    : state == WR  ? (last_wr ? DRAIN : WR)
                    : (last_all ? DRAIN : RD);
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_regs   <= '0;
            wr_strobe <= '0;
            frame_err <= 1'b0;
            bit_cnt   <= '0;
            cmd       <= '0;
            addr      <= '0;
            shadow    <= '0;
            tx        <= '0;
            miso_r    <= 1'b1;
            oe_r      <= 1'b0;
        end else begin
            wr_strobe <= '0;
            if (csb_rise) begin
                bit_cnt <= '0;
                miso_r  <= 1'b1;
                oe_r    <= 1'b0;
            end else begin
                if (csb_fall) begin
                    frame_err <= 1'b0;
                    bit_cnt   <= '0;
                end
                if (sck_rise && state inside {CMD, WR, RD}) bit_cnt <= is_last ? '0 : bit_cnt + 1'b1;
                if (sck_rise && state == CMD) begin
                    cmd <= cmd_full[CMD_W-2:0];
                    if (is_last) begin
                        addr <= cmd_addr;
                        if (!cmd_ok) frame_err <= 1'b1;
                        else if (cmd_full[RD_BIT]) begin
                            tx   <= word_cmd;
                            oe_r <= 1'b1;
                        end
                    end
                end
                if (sck_rise && state == WR) begin
                    shadow <= {shadow[DATA_W-3:0], mosi_s};
                    if (is_last) begin
                        for (int k = 0; k < NUM_WR; k++)
                            if (addr == ADDR_W'(k)) begin
                                wr_regs[k*DATA_W +: DATA_W] <= {shadow, mosi_s};
                                wr_strobe[k] <= 1'b1;
                            end
                        addr <= addr_inc;
                    end
                end
                // a word is only released once the master has sampled its last bit
                if (sck_rise && state == RD && is_last) begin
                    addr <= addr_inc;
                    if (last_all) begin
                        miso_r <= 1'b1;
                        oe_r   <= 1'b0;
                    end else tx <= word_next;
                end
                if (sck_fall && state == RD) begin
                    miso_r <= tx[DATA_W-1];
                    tx     <= {tx[DATA_W-2:0], 1'b0};
                end
            end
        end
endmodule

// File: tb/tb_spi_regfile_subnode.sv
// tb_spi_regfile_subnode: directed SPI frames checked against a word-level register-file model.
module tb_spi_regfile_subnode;
    logic clk = 0, rst = 1;
    logic [63:0] wr_regs;
    logic [3:0] wr_strobe;
    logic [31:0] ro_regs;
    logic frame_err;
    logic [15:0] ro_w [2];
    logic [15:0] mregs [4];
    int mstb [4];
    int strobe_cnt [4];
    logic merr;
    logic settled = 0;
    int total = 0, bad = 0;

    spi_regfile_subnode_if spi();

    spi_regfile_subnode #(.DATA_W(16), .NUM_WR(4), .NUM_RO(2)) dut (
        .clk(clk), .rst(rst), .spi(spi.slave), .wr_regs(wr_regs),
        .wr_strobe(wr_strobe), .ro_regs(ro_regs), .frame_err(frame_err));

    always #5 clk = ~clk;
    assign ro_regs = {ro_w[1], ro_w[0]};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mword(input int a);
        return a < 4 ? mregs[a] : ro_w[a-4];
    endfunction

    // Word-level effect of one frame: commits, strobes, error, and the expected miso stream
    task automatic model_frame(input logic [7:0] c, input int nbits, input logic [63:0] data,
                               output logic [63:0] erd, output int eoe);
        int addr = int'(c[6:0]);
        erd = '0;
        eoe = 0;
        merr = c[7] ? addr >= 6 : addr >= 4;
        for (int i = 0; i < nbits; i++) begin
            int a = addr + i / 16;
            logic [15:0] w;
            if (c[7] && !merr && a < 6) begin
                w = mword(a);
                erd = {erd[62:0], w[15 - i % 16]};
                eoe++;
            end else erd = {erd[62:0], 1'b1};
        end
        if (!c[7] && !merr)
            for (int w = 0; w < nbits / 16 && addr + w < 4; w++) begin
                mregs[addr + w] = data[(nbits - 16 * (w + 1)) +: 16];
                mstb[addr + w]++;
            end
    endtask

    task automatic spi_bit(input logic b, output logic m, output logic o);
        spi.mosi = b;
        #60;
        m = spi.miso;
        o = spi.miso_oe;
        spi.sck = 1;
        #60;
        spi.sck = 0;
    endtask

    task automatic frame(input logic [7:0] c, input int nbits, input logic [63:0] data);
        logic [63:0] rd = '0, erd;
        logic m, o;
        int oe_cnt = 0, cmd_oe = 0, eoe;
        settled = 0;
        model_frame(c, nbits, data, erd, eoe);
        spi.csb = 0;
        #100;
        chk("err_clear_on_csb_fall", {63'd0, frame_err}, 64'd0);
        for (int i = 0; i < 8; i++) begin
            spi_bit(c[7-i], m, o);
            cmd_oe += int'(o);
        end
        for (int i = 0; i < nbits; i++) begin
            spi_bit(data[nbits-1-i], m, o);
            rd = {rd[62:0], m};
            oe_cnt += int'(o);
        end
        #60 spi.csb = 1;
        #200;
        chk("miso_stream", rd, erd);
        chk("miso_oe_data_bits", 64'(oe_cnt), 64'(eoe));
        chk("miso_oe_cmd_bits", 64'(cmd_oe), 64'd0);
        for (int k = 0; k < 4; k++) chk("strobe_count", 64'(strobe_cnt[k]), 64'(mstb[k]));
        settled = 1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("strobe_onehot", 64'($countones(wr_strobe) <= 1), 64'd1);
            for (int k = 0; k < 4; k++) strobe_cnt[k] += int'(wr_strobe[k]);
        end
        if (settled && !rst) begin
            chk("wr_regs", wr_regs, {mregs[3], mregs[2], mregs[1], mregs[0]});
            chk("frame_err", {63'd0, frame_err}, {63'd0, merr});
            chk("idle_miso", {62'd0, spi.miso, spi.miso_oe}, 64'd2);
        end
    end

    initial begin
        logic m, o;
        spi.sck = 0;
        spi.csb = 1;
        spi.mosi = 0;
        ro_w[0] = 16'h1234;
        ro_w[1] = 16'hCAFE;
        merr = 0;
        for (int k = 0; k < 4; k++) begin
            mregs[k] = '0;
            mstb[k] = 0;
            strobe_cnt[k] = 0;
        end
        #23;
        chk("reset_state", {wr_regs[59:0], wr_strobe}, 64'd0);
        chk("reset_pins", {61'd0, spi.miso, spi.miso_oe, frame_err}, 64'd4);
        rst = 0;
        #100 settled = 1;
        frame(8'h01, 16, 64'hA5C3);
        chk("t1_reg1_literal", {48'd0, wr_regs[31:16]}, 64'hA5C3);
        chk("t1_others_literal", {wr_regs[63:32], wr_regs[15:0]}, 64'd0);
        frame(8'h84, 16, 64'h0);
        frame(8'h81, 16, 64'h0);
        frame(8'h85, 32, 64'h0);
        frame(8'h02, 48, 64'h1111_2222_3333);
        chk("t3_burst_literal", {32'd0, wr_regs[63:32]}, 64'h2222_1111);
        chk("t3_no_err_literal", {63'd0, frame_err}, 64'd0);
        frame(8'h00, 10, 64'h3FF);
        chk("t4_partial_literal", {48'd0, wr_regs[15:0]}, 64'd0);
        frame(8'h00, 16, 64'h0F0F);
        frame(8'h05, 16, 64'hFFFF);
        chk("t5_err_write_literal", {63'd0, frame_err}, 64'd1);
        frame(8'h7F, 16, 64'h0);
        chk("t5_err_read_literal", {63'd0, frame_err}, 64'd1);
        settled = 0;
        spi.csb = 0;
        #100;
        for (int i = 0; i < 8; i++) spi_bit(i == 7, m, o);
        for (int i = 0; i < 5; i++) spi_bit(1'b1, m, o);
        #7 rst = 1;
        #1;
        chk("t6_rst_regs", wr_regs, 64'd0);
        chk("t6_rst_pins", {59'd0, wr_strobe, frame_err}, 64'd0);
        chk("t6_rst_miso", {62'd0, spi.miso, spi.miso_oe}, 64'd2);
        for (int k = 0; k < 4; k++) mregs[k] = '0;
        merr = 0;
        spi.csb = 1;
        spi.sck = 0;
        #30 rst = 0;
        #100 settled = 1;
        frame(8'h03, 16, 64'hBEEF);
        chk("t6_reg3_literal", {48'd0, wr_regs[63:48]}, 64'hBEEF);
        frame(8'h83, 16, 64'h0);
        settled = 0;
        #20;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule
